// File: rtl/regfile_wb_arbiter.sv
// Register-file write-back arbiter. Two requesters (ALU and load) share one
// write port under round-robin arbitration. A per-register scoreboard of
// pending writes lets decode stall on RAW/WAW hazards. Registers marked in
// PROT_MASK are never written and never reserved.
module regfile_wb_arbiter #(
    parameter int                  DATA_W    = 32,
    parameter int                  ADDR_W    = 4,
    parameter int                  NUM_REGS  = 16,
    parameter logic [NUM_REGS-1:0] PROT_MASK = 16'hC000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                claim_valid,
    input  logic [ADDR_W-1:0]   claim_reg,
    output logic                claim_stall,
    input  logic                alu_valid,
    input  logic [ADDR_W-1:0]   alu_reg,
    input  logic [DATA_W-1:0]   alu_data,
    output logic                alu_ready,
    input  logic                mem_valid,
    input  logic [ADDR_W-1:0]   mem_reg,
    input  logic [DATA_W-1:0]   mem_data,
    output logic                mem_ready,
    output logic                wr_en,
    output logic [ADDR_W-1:0]   wr_reg,
    output logic [DATA_W-1:0]   wr_data,
    output logic [NUM_REGS-1:0] busy,
    output logic                prot_err
);

    typedef enum logic {GNT_ALU = 1'b0, GNT_MEM = 1'b1} grant_e;

    grant_e              last_q, last_d;
    logic [NUM_REGS-1:0] busy_q, busy_d;
    logic                wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]   wr_reg_q, wr_reg_d;
    logic [DATA_W-1:0]   wr_data_q, wr_data_d;
    logic                perr_q, perr_d;

    logic                xfer;
    logic [ADDR_W-1:0]   g_reg;
    logic [DATA_W-1:0]   g_data;
    logic                g_prot;
    logic                claim_ok;

    // Round-robin grant: on a conflict the requester that did not win last goes.
    assign alu_ready = alu_valid & (~mem_valid | (last_q == GNT_MEM));
    assign mem_ready = mem_valid & (~alu_valid | (last_q == GNT_ALU));

    assign xfer   = alu_ready | mem_ready;
    assign g_reg  = alu_ready ? alu_reg  : mem_reg;
    assign g_data = alu_ready ? alu_data : mem_data;
    assign g_prot = PROT_MASK[g_reg];

    // Protected registers never become busy, so they can never stall.
    assign claim_stall = claim_valid & busy_q[claim_reg];
    assign claim_ok    = claim_valid & ~busy_q[claim_reg] & ~PROT_MASK[claim_reg];

    assign wr_en    = wr_en_q;
    assign wr_reg   = wr_reg_q;
    assign wr_data  = wr_data_q;
    assign busy     = busy_q;
    assign prot_err = perr_q;

    // Next-state: pointer, scoreboard (clear then set, so a same-cycle claim wins) and write port.
    always_comb begin
        last_d    = last_q;
        busy_d    = busy_q;
        wr_en_d   = 1'b0;
        perr_d    = 1'b0;
        wr_reg_d  = wr_reg_q;
        wr_data_d = wr_data_q;
        if (xfer) begin
            last_d        = alu_ready ? GNT_ALU : GNT_MEM;
            busy_d[g_reg] = 1'b0;
            wr_en_d       = ~g_prot;
            perr_d        = g_prot;
            if (!g_prot) begin
                wr_reg_d  = g_reg;
                wr_data_d = g_data;
            end
        end
        if (claim_ok) begin
            busy_d[claim_reg] = 1'b1;
        end
    end

    // State registers; reset discards pending claims and any in-flight write.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_q    <= GNT_MEM;
            busy_q    <= '0;
            wr_en_q   <= 1'b0;
            wr_reg_q  <= '0;
            wr_data_q <= '0;
            perr_q    <= 1'b0;
        end else begin
            last_q    <= last_d;
            busy_q    <= busy_d;
            wr_en_q   <= wr_en_d;
            wr_reg_q  <= wr_reg_d;
            wr_data_q <= wr_data_d;
            perr_q    <= perr_d;
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed vector table, a few hand sequences
// (including asynchronous reset), then random traffic against a model.
module tb_regfile_wb_arbiter;

    localparam logic [15:0] PROT = 16'hC000;

    logic        clk = 1'b0;
    logic        reset;
    logic        claim_valid, claim_stall;
    logic [3:0]  claim_reg;
    logic        alu_valid, alu_ready, mem_valid, mem_ready;
    logic [3:0]  alu_reg, mem_reg;
    logic [31:0] alu_data, mem_data;
    logic        wr_en, prot_err;
    logic [3:0]  wr_reg;
    logic [31:0] wr_data;
    logic [15:0] busy;

    int checks = 0;
    int errors = 0;

    regfile_wb_arbiter dut (
        .clk(clk), .reset(reset),
        .claim_valid(claim_valid), .claim_reg(claim_reg), .claim_stall(claim_stall),
        .alu_valid(alu_valid), .alu_reg(alu_reg), .alu_data(alu_data), .alu_ready(alu_ready),
        .mem_valid(mem_valid), .mem_reg(mem_reg), .mem_data(mem_data), .mem_ready(mem_ready),
        .wr_en(wr_en), .wr_reg(wr_reg), .wr_data(wr_data), .busy(busy), .prot_err(prot_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        cv; logic [3:0] cr;
        logic        av; logic [3:0] ar; logic [31:0] ad;
        logic        mv; logic [3:0] mr; logic [31:0] md;
        logic        ard, mrd, stall;
        logic        wen; logic [3:0] wreg; logic [31:0] wdata;
        logic [15:0] bsy; logic perr;
    } vec_t;

    vec_t vec [17];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic cv, input logic [3:0] cr,
                         input logic av, input logic [3:0] ar, input logic [31:0] ad,
                         input logic mv, input logic [3:0] mr, input logic [31:0] md);
        claim_valid = cv; claim_reg = cr;
        alu_valid = av; alu_reg = ar; alu_data = ad;
        mem_valid = mv; mem_reg = mr; mem_data = md;
    endtask

    task automatic chk_regs(input string nm, input logic wen, input logic [3:0] wreg,
                            input logic [31:0] wdata, input logic [15:0] bsy, input logic perr);
        chk({nm, ".wr_en"}, 64'(wr_en), 64'(wen));
        chk({nm, ".wr_reg"}, 64'(wr_reg), 64'(wreg));
        chk({nm, ".wr_data"}, 64'(wr_data), 64'(wdata));
        chk({nm, ".busy"}, 64'(busy), 64'(bsy));
        chk({nm, ".prot_err"}, 64'(prot_err), 64'(perr));
    endtask

    // Reference model state
    bit          m_last_mem;
    logic [15:0] m_busy;
    logic        m_wen, m_perr;
    logic [3:0]  m_wreg;
    logic [31:0] m_wdata;

    initial begin
        // Directed vectors, applied from reset; expected regs are post-edge values.
        vec[0]  = '{0,0, 1,1,32'h11, 1,2,32'h22, 1,0,0, 1,1,32'h11, 16'h0000,0};
        vec[1]  = '{0,0, 1,1,32'h11, 1,2,32'h22, 0,1,0, 1,2,32'h22, 16'h0000,0};
        vec[2]  = '{0,0, 1,1,32'h11, 1,2,32'h22, 1,0,0, 1,1,32'h11, 16'h0000,0};
        vec[3]  = '{0,0, 1,1,32'h11, 1,2,32'h22, 0,1,0, 1,2,32'h22, 16'h0000,0};
        vec[4]  = '{0,0, 1,3,32'hDEADBEEF, 0,0,0, 1,0,0, 1,3,32'hDEADBEEF, 16'h0000,0};
        vec[5]  = '{0,0, 0,0,0, 0,0,0, 0,0,0, 0,3,32'hDEADBEEF, 16'h0000,0};
        vec[6]  = '{1,5, 0,0,0, 0,0,0, 0,0,0, 0,3,32'hDEADBEEF, 16'h0020,0};
        vec[7]  = '{1,5, 0,0,0, 0,0,0, 0,0,1, 0,3,32'hDEADBEEF, 16'h0020,0};
        vec[8]  = '{1,5, 0,0,0, 1,5,32'h55AA, 0,1,1, 1,5,32'h55AA, 16'h0000,0};
        vec[9]  = '{1,5, 0,0,0, 0,0,0, 0,0,0, 0,5,32'h55AA, 16'h0020,0};
        vec[10] = '{1,7, 1,7,32'h77, 0,0,0, 1,0,0, 1,7,32'h77, 16'h00A0,0};
        vec[11] = '{0,0, 1,14,32'h55, 0,0,0, 1,0,0, 0,7,32'h77, 16'h00A0,1};
        vec[12] = '{1,15, 0,0,0, 0,0,0, 0,0,0, 0,7,32'h77, 16'h00A0,0};
        vec[13] = '{1,15, 0,0,0, 0,0,0, 0,0,0, 0,7,32'h77, 16'h00A0,0};
        vec[14] = '{0,0, 1,5,32'h1, 1,6,32'h2, 0,1,0, 1,6,32'h2, 16'h00A0,0};
        vec[15] = '{0,0, 1,5,32'h1, 0,0,0, 1,0,0, 1,5,32'h1, 16'h0080,0};
        vec[16] = '{1,4, 0,0,0, 1,7,32'h3, 0,1,0, 1,7,32'h3, 16'h0010,0};

        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk_regs("reset", 0, 0, 0, 16'h0000, 0);
        chk("reset.alu_ready", 64'(alu_ready), 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 17; i++) begin
            string nm;
            nm = $sformatf("vec%0d", i);
            @(negedge clk);
            drive(vec[i].cv, vec[i].cr, vec[i].av, vec[i].ar, vec[i].ad,
                  vec[i].mv, vec[i].mr, vec[i].md);
            #1;
            chk({nm, ".alu_ready"}, 64'(alu_ready), 64'(vec[i].ard));
            chk({nm, ".mem_ready"}, 64'(mem_ready), 64'(vec[i].mrd));
            chk({nm, ".claim_stall"}, 64'(claim_stall), 64'(vec[i].stall));
            @(posedge clk); #1;
            chk_regs(nm, vec[i].wen, vec[i].wreg, vec[i].wdata, vec[i].bsy, vec[i].perr);
        end

        // Build busy=00F0 with a write in flight, then reset asynchronously mid-cycle.
        @(negedge clk); drive(1, 5, 0, 0, 0, 0, 0, 0);
        @(negedge clk); drive(1, 6, 0, 0, 0, 0, 0, 0);
        @(negedge clk); drive(1, 7, 1, 1, 32'hAB, 0, 0, 0);
        @(posedge clk); #1;
        chk_regs("pre_arst", 1, 1, 32'hAB, 16'h00F0, 0);
        #2;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        #1;
        chk_regs("arst", 0, 0, 0, 16'h0000, 0);
        @(negedge clk);
        reset = 1'b1;

        // Random traffic against the model; requesters hold until granted.
        m_last_mem = 1'b1; m_busy = '0; m_wen = 0; m_perr = 0; m_wreg = 0; m_wdata = 0;
        begin
            bit a_hold = 0, m_hold = 0;
            for (int c = 0; c < 400; c++) begin
                logic e_ard, e_mrd, e_stall;
                logic [15:0] pre_busy;
                @(negedge clk);
                if (!a_hold) begin
                    alu_valid = 1'($urandom_range(0, 1));
                    alu_reg   = 4'($urandom_range(0, 15));
                    alu_data  = $urandom;
                end
                if (!m_hold) begin
                    mem_valid = 1'($urandom_range(0, 1));
                    mem_reg   = 4'($urandom_range(0, 15));
                    mem_data  = $urandom;
                end
                claim_valid = 1'($urandom_range(0, 1));
                claim_reg   = 4'($urandom_range(0, 15));
                #1;
                if (alu_valid && mem_valid) begin
                    e_ard = m_last_mem;
                    e_mrd = !m_last_mem;
                end else begin
                    e_ard = alu_valid;
                    e_mrd = mem_valid;
                end
                e_stall = claim_valid && m_busy[claim_reg];
                chk("rnd.alu_ready", 64'(alu_ready), 64'(e_ard));
                chk("rnd.mem_ready", 64'(mem_ready), 64'(e_mrd));
                chk("rnd.claim_stall", 64'(claim_stall), 64'(e_stall));
                @(posedge clk);
                pre_busy = m_busy;
                m_wen = 0; m_perr = 0;
                if (e_ard || e_mrd) begin
                    logic [3:0]  g;
                    logic [31:0] d;
                    g = e_ard ? alu_reg : mem_reg;
                    d = e_ard ? alu_data : mem_data;
                    m_busy[g] = 1'b0;
                    if (PROT[g]) m_perr = 1;
                    else begin m_wen = 1; m_wreg = g; m_wdata = d; end
                    m_last_mem = e_mrd;
                end
                if (claim_valid && !pre_busy[claim_reg] && !PROT[claim_reg])
                    m_busy[claim_reg] = 1'b1;
                a_hold = alu_valid && !e_ard;
                m_hold = mem_valid && !e_mrd;
                #1;
                chk_regs("rnd", m_wen, m_wreg, m_wdata, m_busy, m_perr);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
